s_term_ram_io_loopback_bist: RTL and testbench

South-edge terminating block for the RAM_IO column: the counterpart to the north terminator that turns north-going wires around. In functional mode it reflects south-arriving wires back north with per-group index reversal. On request it becomes a loopback self-test: it transmits a 74-pattern sequence up the column, captures the returned wires after a programmable round-trip latency, and reports mismatches.

---
 rtl/s_term_ram_io_loopback_bist_pkg.sv | 27 ++
 rtl/s_term_ram_io_loopback_bist_if.sv | 24 ++
 rtl/s_term_ram_io_loopback_bist_pattern_gen.sv | 23 ++
 rtl/s_term_ram_io_loopback_bist.sv | 124 ++++++++++++
 tb/tb_s_term_ram_io_loopback_bist.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/s_term_ram_io_loopback_bist_pkg.sv
// Shared constants, FSM state type and group-reversal helper for the
// south RAM_IO terminator and its loopback self-test.
package s_term_bist_pkg;

  localparam int unsigned NUM_WIRES    = 36;
  localparam int unsigned NUM_PATTERNS = 74;
  localparam int unsigned IDX_W        = 7;
  localparam logic [6:0]  IDX_NONE     = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Reverse bit order inside each wire group: [3:0], [11:4], [19:12], [35:20].
  function automatic logic [NUM_WIRES-1:0] rev(input logic [NUM_WIRES-1:0] v);
    logic [NUM_WIRES-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)  r[i]      = v[3-i];
    for (int i = 0; i < 8; i++)  r[4+i]    = v[11-i];
    for (int i = 0; i < 8; i++)  r[12+i]   = v[19-i];
    for (int i = 0; i < 16; i++) r[20+i]   = v[35-i];
    return r;
  endfunction

endpackage

// File: rtl/s_term_ram_io_loopback_bist_if.sv
// Self-test control/status bundle.
//   master: drives bist_start/bist_lat, observes status.
//   slave : the terminator; receives requests, drives status.
interface s_term_ram_io_loopback_bist_if #(
  parameter int unsigned ERR_CNT_W = 6
);
  logic                 bist_start;
  logic [3:0]           bist_lat;
  logic                 bist_busy;
  logic                 bist_done;
  logic                 bist_pass;
  logic [ERR_CNT_W-1:0] bist_err_cnt;
  logic [6:0]           bist_first_err_idx;

  modport master (
    output bist_start, bist_lat,
    input  bist_busy, bist_done, bist_pass, bist_err_cnt, bist_first_err_idx
  );

  modport slave (
    input  bist_start, bist_lat,
    output bist_busy, bist_done, bist_pass, bist_err_cnt, bist_first_err_idx
  );
endinterface

// File: rtl/s_term_ram_io_loopback_bist_pattern_gen.sv
// Combinational test pattern p(k) for a 7-bit pattern index.
//   idx   : pattern index 0..73 (others give all-zero)
//   pat_c : 36-bit pattern
module s_term_bist_pattern_gen
  import s_term_bist_pkg::*;
(
  input  logic [6:0]           idx,
  output logic [NUM_WIRES-1:0] pat_c
);

  // 0..35 walking one, 36..71 walking zero, 72 all zero, 73 all one.
  always_comb begin
    pat_c = '0;
    if (idx < 7'd36) begin
      pat_c = NUM_WIRES'(1) << idx;
    end else if (idx < 7'd72) begin
      pat_c = ~(NUM_WIRES'(1) << (idx - 7'd36));
    end else if (idx == 7'd73) begin
      pat_c = '1;
    end
  end

endmodule

// File: rtl/s_term_ram_io_loopback_bist.sv
// South-edge RAM_IO terminator: reflects returning wires north with
// per-group reversal, and on request runs a loopback self-test.
//   UserCLK, rst_n           : clock, async active-low reset
//   S1END/S2MID/S2END/S4END  : returning wires (rx)
//   N1BEG/N2BEG/N2BEGb/N4BEG : north wires (tx)
//   bist                     : self-test control/status (slave modport)
module s_term_ram_io_loopback_bist
  import s_term_bist_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 6
) (
  input  logic        UserCLK,
  input  logic        rst_n,
  input  logic [3:0]  S1END,
  input  logic [7:0]  S2MID,
  input  logic [7:0]  S2END,
  input  logic [15:0] S4END,
  output logic [3:0]  N1BEG,
  output logic [7:0]  N2BEG,
  output logic [7:0]  N2BEGb,
  output logic [15:0] N4BEG,
  s_term_ram_io_loopback_bist_if.slave bist
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;
  localparam logic [6:0]           LAST_IDX = 7'(NUM_PATTERNS - 1);

  state_t               state;
  logic [6:0]           tx_idx;
  logic [NUM_WIRES-1:0] tx_q;
  logic [6:0]           rx_idx;
  logic [3:0]           wait_cnt;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [6:0]           first_idx;
  logic                 done;
  logic                 pass;

  logic [NUM_WIRES-1:0] rx_c;
  logic [NUM_WIRES-1:0] tx_c;
  logic [6:0]           tx_idx_nxt_c;
  logic [NUM_WIRES-1:0] tx_pat_c;
  logic [NUM_WIRES-1:0] exp_pat_c;
  logic                 cmp_c;
  logic                 mismatch_c;
  logic                 last_c;
  logic [ERR_CNT_W-1:0] err_nxt_c;

  assign rx_c = {S4END, S2END, S2MID, S1END};

  // Pattern for the next DRIVE cycle is registered so tx is glitch-free.
  assign tx_idx_nxt_c = (state == IDLE) ? 7'd0 : tx_idx + 7'd1;

  s_term_bist_pattern_gen u_tx_gen  (.idx(tx_idx_nxt_c), .pat_c(tx_pat_c));
  s_term_bist_pattern_gen u_exp_gen (.idx(rx_idx),       .pat_c(exp_pat_c));

  // Compare window opens L cycles after DRIVE cycle 0, regardless of state.
  assign cmp_c      = (state != IDLE) && (wait_cnt == 4'd0);
  assign mismatch_c = cmp_c && (rx_c != rev(exp_pat_c));
  assign last_c     = cmp_c && (rx_idx == LAST_IDX);
  assign err_nxt_c  = (mismatch_c && (err_cnt != ERR_MAX)) ? err_cnt + ERR_CNT_W'(1) : err_cnt;

  // Only DRIVE owns the north wires; otherwise functional reflection.
  assign tx_c = (state == DRIVE) ? tx_q : rev(rx_c);
  assign {N4BEG, N2BEGb, N2BEG, N1BEG} = tx_c;

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_idx    <= '0;
      tx_q      <= '0;
      rx_idx    <= '0;
      wait_cnt  <= '0;
      err_cnt   <= '0;
      first_idx <= IDX_NONE;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bist.bist_start) begin
            state     <= DRIVE;
            tx_idx    <= 7'd0;
            tx_q      <= tx_pat_c;
            rx_idx    <= 7'd0;
            wait_cnt  <= (bist.bist_lat == 4'd0) ? 4'd1 : bist.bist_lat;
            err_cnt   <= '0;
            first_idx <= IDX_NONE;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        DRIVE: begin
          tx_idx <= tx_idx_nxt_c;
          tx_q   <= tx_pat_c;
          if (tx_idx == LAST_IDX) state <= DRAIN;
        end
        DRAIN: ;
        default: state <= IDLE;
      endcase

      // Capture side runs alongside DRIVE/DRAIN; placed last so finishing wins.
      if (state != IDLE) begin
        if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        if (cmp_c) begin
          rx_idx  <= rx_idx + 7'd1;
          err_cnt <= err_nxt_c;
          if (mismatch_c && (err_cnt == '0)) first_idx <= rx_idx;
        end
        if (last_c) begin
          state <= IDLE;
          done  <= 1'b1;
          pass  <= (err_nxt_c == '0);
        end
      end
    end
  end

  assign bist.bist_busy          = (state != IDLE);
  assign bist.bist_done          = done;
  assign bist.bist_pass          = pass;
  assign bist.bist_err_cnt       = err_cnt;
  assign bist.bist_first_err_idx = first_idx;

endmodule

// File: tb/tb_s_term_ram_io_loopback_bist.sv
// Bench for s_term_ram_io_loopback_bist: functional reflection checks and
// loopback self-test runs through a modelled column with injectable faults.
module tb_s_term_ram_io_loopback_bist;

  logic        clk;
  logic        rst_n;
  logic [3:0]  S1END;
  logic [7:0]  S2MID;
  logic [7:0]  S2END;
  logic [15:0] S4END;
  logic [3:0]  N1BEG;
  logic [7:0]  N2BEG;
  logic [7:0]  N2BEGb;
  logic [15:0] N4BEG;

  s_term_ram_io_loopback_bist_if #(.ERR_CNT_W(6)) bif ();

  s_term_ram_io_loopback_bist #(.ERR_CNT_W(6)) dut (
    .UserCLK (clk),
    .rst_n   (rst_n),
    .S1END   (S1END),
    .S2MID   (S2MID),
    .S2END   (S2END),
    .S4END   (S4END),
    .N1BEG   (N1BEG),
    .N2BEG   (N2BEG),
    .N2BEGb  (N2BEGb),
    .N4BEG   (N4BEG),
    .bist    (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [35:0] tx;
  logic [35:0] rx_drv;
  logic [35:0] rx_direct;
  logic [35:0] hist [0:15];
  bit          direct;
  int          dly;
  int          fmode;
  int          fbit;

  assign tx = {N4BEG, N2BEGb, N2BEG, N1BEG};
  assign {S4END, S2END, S2MID, S1END} = rx_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference p(k), built bit by bit from the pattern rules.
  function automatic logic [35:0] m_pat(input int k);
    logic [35:0] p;
    for (int b = 0; b < 36; b++) begin
      if (k < 36)      p[b] = (b == k);
      else if (k < 72) p[b] = (b != k - 36);
      else             p[b] = (k == 73);
    end
    return p;
  endfunction

  // Reference group reversal using group base/size.
  function automatic logic [35:0] m_rev(input logic [35:0] v);
    logic [35:0] r;
    int base, size;
    for (int b = 0; b < 36; b++) begin
      if (b < 4)       begin base = 0;  size = 4;  end
      else if (b < 12) begin base = 4;  size = 8;  end
      else if (b < 20) begin base = 12; size = 8;  end
      else             begin base = 20; size = 16; end
      r[b] = v[base + size - 1 - (b - base)];
    end
    return r;
  endfunction

  // Column fault: 0 none, 1 stuck-0, 2 stuck-1, 3 all inverted.
  function automatic logic [35:0] m_fault(input logic [35:0] v, input int fm, input int fb);
    logic [35:0] r;
    r = v;
    case (fm)
      1: r[fb] = 1'b0;
      2: r[fb] = 1'b1;
      3: r = ~v;
      default: ;
    endcase
    return r;
  endfunction

  // Column loop: returns rev(tx) after dly cycles, through the fault.
  always @(posedge clk) begin
    hist[0] <= tx;
    for (int i = 1; i < 16; i++) hist[i] <= hist[i-1];
  end

  always_comb begin
    if (direct) rx_drv = rx_direct;
    else        rx_drv = m_fault(m_rev(hist[dly-1]), fmode, fbit);
  end

  // Expected self-test result for a given column fault.
  task automatic model(input int fm, input int fb, output int e, output int f);
    logic [35:0] sent;
    e = 0;
    f = 127;
    for (int k = 0; k < 74; k++) begin
      sent = m_rev(m_pat(k));
      if (m_fault(sent, fm, fb) != sent) begin
        if (f == 127) f = k;
        if (e < 63) e++;
      end
    end
  endtask

  task automatic run_bist(input string tag, input int lat, input int fm, input int fb, input bit inject);
    int len, exp_err, exp_first, exp_len;
    model(fm, fb, exp_err, exp_first);
    dly   = (lat == 0) ? 1 : lat;
    fmode = fm;
    fbit  = fb;
    exp_len = 74 + dly;
    @(negedge clk);
    bif.bist_lat   = 4'(lat);
    bif.bist_start = 1'b1;
    @(negedge clk);
    bif.bist_start = 1'b0;
    len = 0;
    while (bif.bist_busy === 1'b1 && len < 400) begin
      len++;
      bif.bist_start = inject && (len == 10);
      bif.bist_lat   = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    bif.bist_start = 1'b0;
    chk({tag, "_busy_len"}, 64'(len), 64'(exp_len));
    chk({tag, "_done"}, 64'(bif.bist_done), 64'd1);
    chk({tag, "_pass"}, 64'(bif.bist_pass), 64'(exp_err == 0));
    chk({tag, "_err_cnt"}, 64'(bif.bist_err_cnt), 64'(exp_err));
    chk({tag, "_first_idx"}, 64'(bif.bist_first_err_idx), 64'(exp_first));
  endtask

  initial begin
    int l;
    logic [35:0] v;
    rst_n          = 1'b0;
    direct         = 1'b1;
    dly            = 1;
    fmode          = 0;
    fbit           = 0;
    bif.bist_start = 1'b0;
    bif.bist_lat   = 4'd0;
    rx_direct      = {16'h0001, 8'h00, 8'h00, 4'b0001};

    repeat (2) @(negedge clk);
    chk("rst_n1beg", 64'(N1BEG), 64'h8);
    chk("rst_n4beg", 64'(N4BEG), 64'h8000);
    chk("rst_busy", 64'(bif.bist_busy), 64'd0);
    chk("rst_done", 64'(bif.bist_done), 64'd0);
    chk("rst_pass", 64'(bif.bist_pass), 64'd0);
    chk("rst_err", 64'(bif.bist_err_cnt), 64'd0);
    chk("rst_first", 64'(bif.bist_first_err_idx), 64'h7F);
    rst_n = 1'b1;

    // Functional reflection with random returning wires.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v = {$urandom, $urandom_range(0, 15)};
      rx_direct = v;
      #1;
      chk("func_rev", 64'(tx), 64'(m_rev(v)));
    end
    direct = 1'b0;
    repeat (4) @(negedge clk);

    run_bist("clean_l3", 3, 0, 0, 1'b0);
    run_bist("stuck_s4end0", 3, 1, 20, 1'b0);
    run_bist("lat0_inject", 0, 0, 0, 1'b1);
    run_bist("inverted", 3, 3, 0, 1'b0);

    // Reset in DRIVE cycle 20.
    dly = 3; fmode = 0;
    @(negedge clk);
    bif.bist_lat   = 4'd3;
    bif.bist_start = 1'b1;
    @(negedge clk);
    bif.bist_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_busy_before", 64'(bif.bist_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bif.bist_busy), 64'd0);
    chk("mid_rst_done", 64'(bif.bist_done), 64'd0);
    chk("mid_rst_err", 64'(bif.bist_err_cnt), 64'd0);
    chk("mid_rst_first", 64'(bif.bist_first_err_idx), 64'h7F);
    chk("mid_rst_tx", 64'(tx), 64'(m_rev(rx_drv)));
    @(negedge clk);
    rst_n = 1'b1;
    run_bist("after_rst", 5, 0, 0, 1'b0);

    // Random latency and column faults.
    for (int i = 0; i < 6; i++) begin
      l = $urandom_range(0, 15);
      run_bist("rand", l, $urandom_range(0, 3), $urandom_range(0, 35), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
